// File: rtl/jk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// jk_ctrl_pkg
// Shared definitions for the JK sequencing controller: operation encodings,
// FSM state type and the default width of the count-length field.
// ---------------------------------------------------------------------------
package jk_ctrl_pkg;

    localparam int LEN_W_DEF = 8;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_CLEAR    = 3'd1,
        OP_SET      = 3'd2,
        OP_TOGGLE   = 3'd3,
        OP_LOAD     = 3'd4,
        OP_COUNT_UP = 3'd5,
        OP_COUNT_DN = 3'd6,
        OP_RSVD     = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/jk_ff_cell.sv
// ---------------------------------------------------------------------------
// jk_ff_cell
// One JK flip-flop with asynchronous active-low reset.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (q -> 0)
//   j, k  : 00 hold, 01 reset, 10 set, 11 toggle
//   q     : stored bit
//   q_bar : complement of q
// ---------------------------------------------------------------------------
module jk_ff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/jk_seq_ctrl.sv
// ---------------------------------------------------------------------------
// jk_seq_ctrl
// Command-driven controller that owns a bank of WIDTH JK flip-flops and
// generates their per-bit J/K drive: clear, set, toggle, load and multi-cycle
// up/down counting. Commands are accepted through a valid/ready handshake
// only while IDLE; a command runs in EXEC and completes through a one-cycle
// DONE state.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cmd_valid  : command offered
//   cmd_ready  : controller can accept (IDLE only)
//   cmd_op     : operation code (jk_ctrl_pkg::op_e)
//   cmd_data   : load value / toggle mask
//   cmd_len    : number of EXEC cycles for count ops (0 = one idle cycle)
//   q          : JK bank state
//   busy       : high in EXEC and DONE
//   done       : one-cycle pulse at command completion
//   wrap       : sticky, a count hit its bound during the current/last command
//
// Build option:
//   JK_SATURATE_EN : when defined, counts stop at their bound instead of
//                    wrapping; wrap still flags the first blocked cycle.
// ---------------------------------------------------------------------------
module jk_seq_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic               wrap_q, wrap_d;

    logic [WIDTH-1:0]   j_s, k_s;
    logic [WIDTH-1:0]   q_bits, qb_bits;
    logic [WIDTH-1:0]   up_en, dn_en;
    logic               at_top, at_bot;

    // JK register bank
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_ff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j_s[g]),
            .k     (k_s[g]),
            .q     (q_bits[g]),
            .q_bar (qb_bits[g])
        );
    end

    // Ripple enables for counting: bit i toggles when all lower bits are 1
    // (up) or all lower bits are 0 (down). Bit 0 always toggles.
    always_comb begin
        logic up_acc;
        logic dn_acc;
        up_acc = 1'b1;
        dn_acc = 1'b1;
        up_en  = '0;
        dn_en  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_en[i] = up_acc;
            dn_en[i] = dn_acc;
            up_acc   = up_acc & q_bits[i];
            dn_acc   = dn_acc & qb_bits[i];
        end
    end

    assign at_top = &q_bits;
    assign at_bot = &qb_bits;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statements can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        wrap_d  = wrap_q;
        j_s     = '0;
        k_s     = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_EXEC;
                    op_d    = op_e'(cmd_op);
                    data_d  = cmd_data;
                    rem_d   = cmd_len;
                    wrap_d  = 1'b0;
                end
            end

            S_EXEC: begin
                state_d = S_DONE;
                unique case (op_q)
                    OP_CLEAR: begin
                        k_s = '1;
                    end
                    OP_SET: begin
                        j_s = '1;
                    end
                    OP_TOGGLE: begin
                        j_s = data_q;
                        k_s = data_q;
                    end
                    OP_LOAD: begin
                        j_s = data_q;
                        k_s = ~data_q;
                    end
                    OP_COUNT_UP, OP_COUNT_DN: begin
                        // rem_q == 0 only for a zero-length count: one
                        // EXEC cycle with no drive.
                        if (rem_q != '0) begin
                            if ((op_q == OP_COUNT_UP) ? at_top : at_bot) begin
                                wrap_d = 1'b1;
`ifdef JK_SATURATE_EN
                            end else begin
                                j_s = (op_q == OP_COUNT_UP) ? up_en : dn_en;
                                k_s = (op_q == OP_COUNT_UP) ? up_en : dn_en;
                            end
`else
                            end
                            j_s = (op_q == OP_COUNT_UP) ? up_en : dn_en;
                            k_s = (op_q == OP_COUNT_UP) ? up_en : dn_en;
`endif
                        end
                        if (rem_q > LEN_W'(1)) begin
                            state_d = S_EXEC;
                            rem_d   = rem_q - LEN_W'(1);
                        end
                    end
                    default: ; // NOP and reserved: no drive
                endcase
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the latched command fields are a few flops, not a memory, so they
    // are reset along with the state for a fully known post-reset image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            wrap_q  <= wrap_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign wrap      = wrap_q;
    assign q         = q_bits;

endmodule
